// File: rtl/bit_word_packer.sv
// Serial-to-parallel word packer: frames an MSB-first bitstream into WORD_W-bit words behind a small FIFO.
// Define WORD_PACK_STATS_EN to add the word_cnt / drop_cnt statistics outputs.
module bit_word_packer #(
    parameter int WORD_W     = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    input  logic                         sof,
    output logic [WORD_W-1:0]            word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(WORD_W+1)-1:0]  fill_cnt,
    output logic                         drop_pulse,
    output logic                         abort_pulse
`ifdef WORD_PACK_STATS_EN
    ,
    output logic [15:0]                  word_cnt,
    output logic [7:0]                   drop_cnt
`endif
);

    localparam int FW = $clog2(WORD_W+1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    typedef enum logic {HUNT, FILL} state_t;

    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]       count, cnt_nxt;
    logic [FW-1:0]       cnt_in;
    logic [WORD_W-1:0]   word_p0;
    logic                take, start, push, pop, push_ok, drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        start   = bit_valid && sof;
        take    = bit_valid && (sof || state == FILL);
        // An sof bit always begins a fresh word, discarding whatever was collected.
        cnt_in  = start ? '0 : fill_cnt;
        word_p0 = start ? {{(WORD_W-1){1'b0}}, bit_in} : {shreg[WORD_W-2:0], bit_in};
        push    = take && (cnt_in == FW'(WORD_W-1));
        pop     = word_valid && word_ready;
        push_ok = push && ((count != CW'(FIFO_DEPTH)) || pop);
        drop    = push && !push_ok;
        rd_nxt  = rd_ptr + PW'(pop);
        cnt_nxt = count + CW'(push_ok) - CW'(pop);
    end

    // Stage p0: bit assembly and FIFO storage (data, no reset)
    always_ff @(posedge clk) begin
        if (take)
            shreg <= word_p0;
        if (push_ok)
            mem[wr_ptr] <= word_p0;
    end

    // Stage p1: framing FSM, FIFO control and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            fill_cnt    <= '0;
            drop_pulse  <= 1'b0;
            abort_pulse <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            word_valid  <= 1'b0;
            word_out    <= '0;
        end else begin
            abort_pulse <= start && (state == FILL) && (fill_cnt != '0);
            drop_pulse  <= drop;
            if (take) begin
                state    <= FILL;
                fill_cnt <= push ? '0 : cnt_in + FW'(1);
            end
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr     <= rd_nxt;
            count      <= cnt_nxt;
            word_valid <= (cnt_nxt != '0);
            // The incoming word becomes head directly when nothing older remains queued.
            if (push_ok && (count == CW'(pop)))
                word_out <= word_p0;
            else if (pop && (cnt_nxt != '0))
                word_out <= mem[rd_nxt];
        end
    end

`ifdef WORD_PACK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok)
                word_cnt <= word_cnt + 16'd1;
            if (drop)
                drop_cnt <= sat_inc8(drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_bit_word_packer.sv
// Directed self-checking bench for bit_word_packer (WORD_W=10, FIFO_DEPTH=2).
module tb_bit_word_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in, bit_valid, sof, word_ready;
    logic [9:0] word_out;
    logic       word_valid, drop_pulse, abort_pulse;
    logic [3:0] fill_cnt;
`ifdef WORD_PACK_STATS_EN
    logic [15:0] word_cnt;
    logic [7:0]  drop_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    bit_word_packer #(.WORD_W(10), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .fill_cnt(fill_cnt), .drop_pulse(drop_pulse), .abort_pulse(abort_pulse)
`ifdef WORD_PACK_STATS_EN
        , .word_cnt(word_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        bit_in = b; bit_valid = 1'b1; sof = s;
        tick();
        bit_valid = 1'b0; sof = 1'b0; bit_in = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w, input logic s, input logic rdy_last);
        for (int i = 9; i >= 0; i--) begin
            bit_in = w[i]; bit_valid = 1'b1; sof = (i == 9) && s;
            if (i == 0 && rdy_last) word_ready = 1'b1;
            tick();
        end
        bit_valid = 1'b0; sof = 1'b0; bit_in = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, word_valid, 0);
        check({tag, "_out"},   word_out,   0);
        check({tag, "_fill"},  fill_cnt,   0);
        check({tag, "_drop"},  drop_pulse, 0);
        check({tag, "_abort"}, abort_pulse, 0);
    endtask

    initial begin
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0; word_ready = 1'b1;
        tick(); tick();
        check_idle_outputs("rst");
        #2 rst_n = 1'b1;
        tick();

        // 1: single framed word 1010000101
        send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(0, 0);
        check("t1_fill5", fill_cnt, 5);
        check("t1_valid_early", word_valid, 0);
        send_bit(0, 0); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        check("t1_valid", word_valid, 1);
        check("t1_word", word_out, 10'h285);
        check("t1_fill0", fill_cnt, 0);
        tick();
        check("t1_valid_gone", word_valid, 0);
        check("t1_word_hold", word_out, 10'h285);

        // 2: consumer stalled, third word overflows
        word_ready = 1'b0;
        send_word(10'h2AA, 1, 0);
        check("t2_w1_valid", word_valid, 1);
        check("t2_w1_out", word_out, 10'h2AA);
        send_word(10'h155, 0, 0);
        check("t2_w2_drop", drop_pulse, 0);
        check("t2_w2_head", word_out, 10'h2AA);
        send_word(10'h3FF, 0, 0);
        check("t2_drop", drop_pulse, 1);
        check("t2_head_kept", word_out, 10'h2AA);
        tick();
        check("t2_drop_once", drop_pulse, 0);
        word_ready = 1'b1;
        tick();
        check("t2_pop1_valid", word_valid, 1);
        check("t2_pop1_out", word_out, 10'h155);
        tick();
        check("t2_pop2_valid", word_valid, 0);
        check("t2_pop2_hold", word_out, 10'h155);

        // 3: full FIFO with a pop on the completing edge
        word_ready = 1'b0;
        send_word(10'h001, 1, 0);
        send_word(10'h002, 0, 0);
        send_word(10'h003, 0, 1);
        check("t3_no_drop", drop_pulse, 0);
        check("t3_second", word_out, 10'h002);
        tick();
        check("t3_third_valid", word_valid, 1);
        check("t3_third", word_out, 10'h003);
        tick();
        check("t3_empty", word_valid, 0);

        // 4: mid-word sof aborts the partial word
        send_bit(0, 1); send_bit(0, 0); send_bit(0, 0); send_bit(0, 0);
        check("t4_fill4", fill_cnt, 4);
        send_bit(1, 1);
        check("t4_abort", abort_pulse, 1);
        check("t4_fill1", fill_cnt, 1);
        send_bit(1, 0);
        check("t4_abort_once", abort_pulse, 0);
        for (int i = 0; i < 7; i++) send_bit(1, 0);
        check("t4_not_yet", word_valid, 0);
        send_bit(1, 0);
        check("t4_valid", word_valid, 1);
        check("t4_word", word_out, 10'h3FF);
        tick();
        check("t4_single", word_valid, 0);

        // 5: bits before any sof are ignored; gaps mid-word hold state
        rst_n = 1'b0; #2;
        check("t5_rst_out", word_out, 0);
        tick(); #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) send_bit(i[0], 0);
        check("t5_hunt_fill", fill_cnt, 0);
        check("t5_hunt_valid", word_valid, 0);
        send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        tick(); tick();
        sof = 1'b1; tick(); sof = 1'b0;
        check("t5_gap_fill", fill_cnt, 5);
        check("t5_gap_abort", abort_pulse, 0);
        send_bit(0, 0); send_bit(0, 0); send_bit(1, 0); tick(); send_bit(0, 0); send_bit(1, 0);
        check("t5_valid", word_valid, 1);
        check("t5_word", word_out, 10'h2C5);
        tick();

        // 6: asynchronous reset with a queued word and a partial word
        word_ready = 1'b0;
        send_word(10'h0F0, 1, 0);
        check("t6_queued", word_out, 10'h0F0);
        send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
        check("t6_fill6", fill_cnt, 6);
        rst_n = 1'b0; #1;
        check_idle_outputs("t6_rst");
        tick(); #2 rst_n = 1'b1;
        word_ready = 1'b1;
        send_word(10'h3FF, 0, 0);
        check("t6_ignored_valid", word_valid, 0);
        check("t6_ignored_fill", fill_cnt, 0);
        tick();
        check("t6_still_empty", word_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
